// File: rtl/led_frame_writer.sv
// Double-buffered 16-column frame writer: renders two digits plus a unit glyph
// into the back buffer and swaps it to the scanner only on a frame boundary.
module led_frame_writer #(
  parameter bit         BLANK_LZ  = 1'b1,
  parameter logic [3:0] UNIT_CODE = 4'd12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       frame_sync,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RENDER    = 2'd1,
    WAIT_SWAP = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] mem_q [2][16];
  logic       front_sel_q;
  logic [3:0] col_q;
  logic [3:0] tens_q, ones_q;
  logic       pend_q;
  logic [3:0] pend_tens_q, pend_ones_q;
  logic [7:0] rd_data_q;
  logic       busy_q, done_q;
  logic [7:0] wr_data_d;

  // Active-high column bitmap for one glyph column; codes 13-15 fall back to dash.
  function automatic logic [7:0] glyph_col(input logic [3:0] code, input logic [1:0] idx);
    logic [31:0] g;
    case (code)
      4'd0:    g = 32'h3E41_413E;
      4'd1:    g = 32'h1131_7F01;
      4'd2:    g = 32'h2345_4931;
      4'd3:    g = 32'h2249_4936;
      4'd4:    g = 32'h0C14_247F;
      4'd5:    g = 32'h7A49_4946;
      4'd6:    g = 32'h3E49_4926;
      4'd7:    g = 32'h4045_4970;
      4'd8:    g = 32'h3649_4936;
      4'd9:    g = 32'h3249_493E;
      4'd10:   g = 32'h0000_0000;
      4'd12:   g = 32'hC0DE_2121;
      default: g = 32'h0808_0808;
    endcase
    case (idx)
      2'd0:    return g[31:24];
      2'd1:    return g[23:16];
      2'd2:    return g[15:8];
      default: return g[7:0];
    endcase
  endfunction

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    wr_data_d = 8'hFF;
    if (col_q <= 4'd3) begin
      wr_data_d = ~glyph_col((BLANK_LZ && tens_q == 4'd0) ? 4'd10 : tens_q, col_q[1:0]);
    end else if (col_q >= 4'd5 && col_q <= 4'd8) begin
      wr_data_d = ~glyph_col(ones_q, 2'(col_q - 4'd5));
    end else if (col_q >= 4'd10 && col_q <= 4'd13) begin
      wr_data_d = ~glyph_col(UNIT_CODE, 2'(col_q - 4'd10));
    end
  end

  // NOTE: the buffers are reset too, so a reset mid-render leaves a blank display
  // rather than stale or half-written pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < 16; c++) begin
          mem_q[b][c] <= 8'hFF;
        end
      end
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      col_q       <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      pend_q      <= 1'b0;
      pend_tens_q <= 4'd0;
      pend_ones_q <= 4'd0;
      rd_data_q   <= 8'hFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the read below see the pre-swap front_sel_q.
      rd_data_q <= mem_q[front_sel_q][rd_addr];
      done_q    <= 1'b0;

      if (start && state_q != IDLE) begin
        pend_q      <= 1'b1;
        pend_tens_q <= tens;
        pend_ones_q <= ones;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            tens_q  <= tens;
            ones_q  <= ones;
            col_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= RENDER;
          end
        end
        RENDER: begin
          mem_q[!front_sel_q][col_q] <= wr_data_d;
          col_q <= col_q + 4'd1;
          if (col_q == 4'd15) begin
            state_q <= WAIT_SWAP;
          end
        end
        WAIT_SWAP: begin
          if (frame_sync) begin
            front_sel_q <= !front_sel_q;
            done_q      <= 1'b1;
            if (start || pend_q) begin
              // A start on the swap edge is the freshest request and wins.
              tens_q  <= start ? tens : pend_tens_q;
              ones_q  <= start ? ones : pend_ones_q;
              pend_q  <= 1'b0;
              col_q   <= 4'd0;
              state_q <= RENDER;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/led_frame_writer.md
Name: led_frame_writer

Overview:
- Renders a two-digit reading plus a unit symbol into a 16-column x 8-bit frame buffer.
- The matrix scanner reads that buffer one column per row-strobe through a registered read port.
- The buffer is double-buffered: rendering goes to the back buffer, and buffers swap only on the scanner's frame boundary, so the display never shows a half-written frame.
- This block is the writer and owner of the column memory; the scanner is its reader.

Parameters:
- BLANK_LZ, 1, 1 = a tens digit of 0 renders as blank columns; 0 = renders glyph "0".
- UNIT_CODE, 12, glyph code rendered in columns 10-13.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request to render a new frame
- tens  in  4  glyph code for the tens position
- ones  in  4  glyph code for the ones position
- frame_sync  in  1  pulse from the scanner when column 15 finishes; a swap is permitted here
- rd_addr  in  4  column index requested by the scanner
- rd_data  out  8  column pixels from the front buffer, active-low (0 = LED on)
- busy  out  1  high while rendering or waiting for swap
- done  out  1  one-cycle pulse after a buffer swap

Behaviour:
- Reset (async, immediate):
  - Both buffers are set to 8'hFF in all 16 entries.
  - front_sel=0, state=IDLE, rd_data=8'hFF, busy=0, done=0, pending flag cleared.
- Glyph ROM: 4 columns per code, active-high bits listed col0..col3; stored and output inverted.
  - 0: 3E 41 41 3E
  - 1: 11 31 7F 01
  - 2: 23 45 49 31
  - 3: 22 49 49 36
  - 4: 0C 14 24 7F
  - 5: 7A 49 49 46
  - 6: 3E 49 49 26
  - 7: 40 45 49 70
  - 8: 36 49 49 36
  - 9: 32 49 49 3E
  - 10 (blank): 00 00 00 00
  - 11 (dash): 08 08 08 08
  - 12 (degree-C): C0 DE 21 21
  - 13-15: render as dash (code 11)
- Frame layout:
  - cols 0-3: tens glyph
  - col 4: blank
  - cols 5-8: ones glyph
  - col 9: blank
  - cols 10-13: UNIT_CODE glyph
  - cols 14-15: blank
  - Blank column value is 8'hFF.
- Read port: rd_data is registered from front buffer[rd_addr], 1-cycle latency. On the swap edge the read still uses the old front buffer; the new buffer is visible from the next edge.
- FSM IDLE:
  - On start, capture tens/ones, set busy=1, then go to RENDER with col=0.
- FSM RENDER:
  - Write one column per cycle to the back buffer (the buffer not selected by front_sel), col 0..15; exactly 16 cycles.
  - After col 15 is written, go to WAIT_SWAP.
  - The front buffer is never written.
- FSM WAIT_SWAP:
  - On the first edge with frame_sync=1, toggle front_sel.
  - busy falls and done=1 for the following cycle only.
  - Next state is IDLE, or RENDER if a request is pending.
- frame_sync in IDLE or RENDER: ignored, no swap.
- start while busy:
  - Latched as a single-deep pending request with the tens/ones values sampled at that edge.
  - A later start overwrites the pending values.
  - The pending request is served immediately after the swap; busy stays 1 in that case and done still pulses.
- start and frame_sync on the same edge in WAIT_SWAP: swap occurs, the request becomes pending, and rendering begins on the next cycle.
- Latency: start sampled at edge E0 → writes at E1..E16 → earliest swap at E17 (frame_sync high) → done high during the cycle after E17.
- Reset mid-render: the back buffer contents are discarded (all FF), the display shows a blank frame, and there is no done pulse.

Test Plan:
- Reset, then read rd_addr 0..15 → rd_data=FF for every column; busy=0, done=0.
- Render: start with tens=2, ones=5, frame_sync held 0 → busy=1 and front reads stay FF. Pulse frame_sync → exactly one done pulse. Reads then return:
  - col0-3: DC BA B6 CE
  - col4: FF
  - col5-8: 85 B6 B6 B9
  - col10-13: 3F 21 DE DE
- BLANK_LZ=1 with tens=0, ones=7 → col0-3 = FF, col5-8 = BF BA B6 8F. With BLANK_LZ=0, col0-3 = C1 BE BE C1.
- Queued request: issue start(1,1) during RENDER of (2,5), then frame_sync → first swap shows 25 and busy stays 1. A second frame_sync shows 11 (col0-3 = EE CE 80 FE); two done pulses in total.
- Code 14 in the ones position → col5-8 = F7 F7 F7 F7. frame_sync during RENDER → no swap, done stays 0.
- Assert rst at render cycle 8 → immediate blank reads (FF), busy=0. A new start renders correctly.
